// File: rtl/fifo_serial_tx.sv
// fifo_serial_tx: drains a byte FIFO and sends each word as an 8N1 async serial frame, LSB first.
// Latency: nempty seen in IDLE at posedge N -> rdReq in cycle N+1, word captured and txd falls at N+2.
// Backpressure: never reads an empty FIFO; en low holds off new frames, but a frame in flight completes.
//
// Ports:
//   pclk     system clock, all state on posedge
//   clear    asynchronous active-low reset
//   en       enable for starting new frames
//   nempty   FIFO non-empty flag
//   intr     FIFO full flag (status only, feeds ovfWarn)
//   wordIn   FIFO output word, valid the cycle after rdReq
//   rdReq    one-cycle FIFO read strobe
//   fifoEn   FIFO enable, mirrors rdReq
//   txd      serial line, idles high
//   busy     high from rdReq through the end of the last idle bit
//   ovfWarn  sticky: intr seen while busy
//
// Build option: define PARITY_EN to append an even-parity bit after the data bits (11-bit frame).
module fifo_serial_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int IDLE_BITS    = 1
) (
  input  logic       pclk,
  input  logic       clear,
  input  logic       en,
  input  logic       nempty,
  input  logic       intr,
  input  logic [7:0] wordIn,
  output logic       rdReq,
  output logic       fifoEn,
  output logic       txd,
  output logic       busy,
  output logic       ovfWarn
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOAD   = 3'd1;
  localparam logic [2:0] S_START  = 3'd2;
  localparam logic [2:0] S_DATA   = 3'd3;
`ifdef PARITY_EN
  localparam logic [2:0] S_PARITY = 3'd4;
`endif
  localparam logic [2:0] S_STOP   = 3'd5;
  localparam logic [2:0] S_GAP    = 3'd6;

  localparam int             BW        = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0]  BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam bit             HAS_GAP   = (IDLE_BITS > 0);
  localparam logic [3:0]     GAP_LAST  = 4'(IDLE_BITS > 0 ? IDLE_BITS - 1 : 0);

  logic [2:0]    state;
  logic [7:0]    shreg;
  logic [3:0]    bit_cnt;   // data bit index in DATA, idle bit index in GAP
  logic [BW-1:0] baud_cnt;
  logic          baud_tick;
  logic          frame_end;
`ifdef PARITY_EN
  logic          par_bit;   // parity of the captured byte; shreg is consumed while shifting
`endif

  assign baud_tick = (baud_cnt == BAUD_LAST);
  assign fifoEn    = rdReq;

  // Last cycle of the last stop-level bit of a frame.
  assign frame_end = baud_tick &&
                     (((state == S_STOP) && !HAS_GAP) ||
                      ((state == S_GAP) && (bit_cnt == GAP_LAST)));

  always_ff @(posedge pclk or negedge clear) begin
    if (!clear) begin
      state    <= S_IDLE;
      shreg    <= '0;
      bit_cnt  <= '0;
      baud_cnt <= '0;
      rdReq    <= 1'b0;
      busy     <= 1'b0;
      txd      <= 1'b1;
      ovfWarn  <= 1'b0;
`ifdef PARITY_EN
      par_bit  <= 1'b0;
`endif
    end else begin
      if (intr && busy) ovfWarn <= 1'b1;

      if ((state == S_IDLE) || (state == S_LOAD) || baud_tick) baud_cnt <= '0;
      else                                                     baud_cnt <= baud_cnt + 1'b1;

      case (state)
        // The read strobe cycle is spent in IDLE so that rdReq never coexists with
        // any other state; the FIFO word then arrives in time for LOAD.
        S_IDLE: begin
          if (rdReq) begin
            rdReq <= 1'b0;
            state <= S_LOAD;
          end else if (en && nempty) begin
            rdReq <= 1'b1;
            busy  <= 1'b1;
          end
        end
        S_LOAD: begin
          shreg <= wordIn;
`ifdef PARITY_EN
          par_bit <= ^wordIn;
`endif
          txd   <= 1'b0;
          state <= S_START;
        end
        S_START: begin
          if (baud_tick) begin
            txd     <= shreg[0];
            bit_cnt <= '0;
            state   <= S_DATA;
          end
        end
        S_DATA: begin
          if (baud_tick) begin
            shreg   <= shreg >> 1;
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == 4'd7) begin
`ifdef PARITY_EN
              txd   <= par_bit;
              state <= S_PARITY;
`else
              txd   <= 1'b1;
              state <= S_STOP;
`endif
            end else begin
              txd <= shreg[1];
            end
          end
        end
`ifdef PARITY_EN
        S_PARITY: begin
          if (baud_tick) begin
            txd   <= 1'b1;
            state <= S_STOP;
          end
        end
`endif
        S_STOP: begin
          if (baud_tick && HAS_GAP) begin
            bit_cnt <= '0;
            state   <= S_GAP;
          end
        end
        S_GAP: begin
          if (baud_tick && (bit_cnt != GAP_LAST)) bit_cnt <= bit_cnt + 1'b1;
        end
        default: begin
          txd   <= 1'b1;
          state <= S_IDLE;
        end
      endcase

      // Back-to-back frames: the next read is issued on the same edge that
      // returns to IDLE, so busy stays high and frames are spaced frame+2 cycles.
      if (frame_end) begin
        state <= S_IDLE;
        if (en && nempty) rdReq <= 1'b1;
        else              busy  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fifo_serial_tx.sv
// Bench for fifo_serial_tx: FIFO model feeds the DUT, a line monitor decodes
// frames from txd and checks them against the queue of words written.
module tb_fifo_serial_tx;

  localparam int CPB = 4;
  localparam int IB  = 1;
`ifdef PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int FRAME_CYC = (NBITS + IB) * CPB;

  logic       pclk   = 1'b0;
  logic       clear  = 1'b0;
  logic       en     = 1'b0;
  logic       nempty = 1'b0;
  logic       intr   = 1'b0;
  logic [7:0] wordIn = 8'h00;
  logic       rdReq, fifoEn, txd, busy, ovfWarn;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int rdreq_pulses = 0;
  logic [7:0] fifo_q[$];
  logic [7:0] sb_q[$];
  int         start_q[$];

  fifo_serial_tx #(.CLKS_PER_BIT(CPB), .IDLE_BITS(IB)) dut (
    .pclk(pclk), .clear(clear), .en(en), .nempty(nempty), .intr(intr),
    .wordIn(wordIn), .rdReq(rdReq), .fifoEn(fifoEn), .txd(txd),
    .busy(busy), .ovfWarn(ovfWarn)
  );

  always #5 pclk = ~pclk;
  always @(posedge pclk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    errors++;
    $display("FAIL timeout %s (cycle %0d)", name, cyc);
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge pclk);
    #1;
  endtask

  task automatic push(input logic [7:0] b);
    int g = 0;
    while (fifo_q.size() >= 4 && g < 2000) begin
      tick();
      g++;
    end
    if (g >= 2000) timeout_fail("push");
    fifo_q.push_back(b);
    sb_q.push_back(b);
  endtask

  task automatic wait_busy(input logic lvl, input string name);
    int g = 0;
    while (busy !== lvl && g < 1000) begin
      tick();
      g++;
    end
    if (g >= 1000) timeout_fail(name);
  endtask

  task automatic wait_txd_low(input string name);
    int g = 0;
    while (txd !== 1'b0 && g < 1000) begin
      tick();
      g++;
    end
    if (g >= 1000) timeout_fail(name);
  endtask

  task automatic wait_idle(input string name);
    int g  = 0;
    int ok = 0;
    while (ok < 2 && g < 5000) begin
      tick();
      g++;
      if (!busy && !rdReq && fifo_q.size() == 0 && sb_q.size() == 0) ok++;
      else ok = 0;
    end
    if (ok < 2) timeout_fail(name);
  endtask

  // FIFO model: word appears on wordIn the cycle after rdReq.
  initial forever begin
    @(negedge pclk);
    if (clear && rdReq) begin
      chk("rdreq_nonempty", fifo_q.size() != 0, 1);
      if (fifo_q.size() != 0) wordIn = fifo_q.pop_front();
    end
    nempty = (fifo_q.size() != 0);
  end

  // Strobe rules.
  initial begin : proto
    logic prev;
    prev = 1'b0;
    forever begin
      @(negedge pclk);
      if (clear) begin
        chk("fifoen_eq_rdreq", fifoEn, rdReq);
        chk("rdreq_single", rdReq & prev, 0);
        if (rdReq) rdreq_pulses++;
        prev = rdReq;
      end else begin
        prev = 1'b0;
      end
    end
  end

  // Line monitor: every bit must hold for exactly CPB samples.
  initial begin : mon
    int ms;
    logic [NBITS-1:0] bits;
    bit herr, berr;
    logic [7:0] data, exp;
    ms = -1;
    bits = '0;
    herr = 0;
    berr = 0;
    forever begin
      @(negedge pclk);
      if (!clear) begin
        ms = -1;
        continue;
      end
      if (ms < 0 && txd === 1'b0) begin
        ms = 0;
        bits = '0;
        herr = 0;
        berr = 0;
        start_q.push_back(cyc);
      end
      if (ms >= 0) begin
        if (busy !== 1'b1) berr = 1;
        if (ms % CPB == 0) bits[ms / CPB] = txd;
        else if (txd !== bits[ms / CPB]) herr = 1;
        ms++;
        if (ms == NBITS * CPB) begin
          data = bits[8:1];
          chk("frame_bit_hold", herr, 0);
          chk("frame_busy", berr, 0);
          chk("stop_bit", bits[NBITS-1], 1);
`ifdef PARITY_EN
          chk("parity_bit", bits[9], ^data);
`endif
          if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_frame: actual=%0h expected=none", data);
          end else begin
            exp = sb_q.pop_front();
            chk("frame_data", data, exp);
          end
          ms = -1;
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int bcnt, g, p0;
    tick(3);
    chk("rst_txd", txd, 1);
    chk("rst_rdreq", rdReq, 0);
    chk("rst_fifoen", fifoEn, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ovf", ovfWarn, 0);
    clear = 1'b1;
    tick(5);
    chk("idle_no_req", rdreq_pulses, 0);
    chk("idle_txd", txd, 1);

    // Single word, latency and busy length.
    en = 1'b1;
    push(8'hA5);
    g = 0;
    do begin
      @(posedge pclk);
      g++;
    end while (!nempty && g < 100);
    #1;
    chk("lat_rdreq", rdReq, 1);
    chk("lat_busy", busy, 1);
    tick();
    chk("lat_rdreq_drop", rdReq, 0);
    chk("lat_txd_pre", txd, 1);
    tick();
    chk("lat_txd_fall", txd, 0);
    bcnt = 3;
    g = 0;
    while (g < 500) begin
      tick();
      if (!busy) break;
      bcnt++;
      g++;
    end
    chk("busy_len", bcnt, FRAME_CYC + 2);
    wait_idle("a5");

    // Enable gating.
    en = 1'b0;
    push(8'hFF);
    push(8'h5A);
    p0 = rdreq_pulses;
    tick(20);
    chk("en_low_no_req", rdreq_pulses - p0, 0);
    chk("en_low_txd", txd, 1);
    en = 1'b1;
    wait_txd_low("en_start");
    tick(CPB * 4);
    en = 1'b0;
    p0 = rdreq_pulses;
    wait_busy(1'b0, "en_frame_end");
    tick(CPB * 6);
    chk("en_mid_no_second", rdreq_pulses - p0, 0);
    chk("en_mid_pending", nempty, 1);
    chk("en_mid_sb", sb_q.size(), 1);
    en = 1'b1;
    wait_idle("en");

    // Burst of four: back-to-back spacing.
    start_q.delete();
    p0 = rdreq_pulses;
    for (int i = 1; i <= 4; i++) push(8'(i));
    wait_idle("burst");
    chk("burst_pulses", rdreq_pulses - p0, 4);
    chk("burst_frames", start_q.size(), 4);
    for (int i = 1; i < start_q.size(); i++)
      chk("burst_spacing", start_q[i] - start_q[i-1], FRAME_CYC + 2);

    // Overflow warning; parity-relevant words 07 and 03.
    chk("ovf_pre", ovfWarn, 0);
    intr = 1'b1;
    tick(3);
    chk("ovf_idle", ovfWarn, 0);
    intr = 1'b0;
    push(8'h07);
    wait_busy(1'b1, "ovf_busy");
    tick(5);
    intr = 1'b1;
    tick(2);
    intr = 1'b0;
    tick();
    chk("ovf_set", ovfWarn, 1);
    push(8'h03);
    wait_idle("ovf");
    chk("ovf_sticky", ovfWarn, 1);

    // Reset in data bit 3.
    push(8'hC3);
    wait_txd_low("rst_start");
    tick(CPB * 4 + 1);
    chk("pre_reset_bit3", txd, 0);
    #2;
    clear = 1'b0;
    #1;
    chk("midrst_txd", txd, 1);
    chk("midrst_busy", busy, 0);
    chk("midrst_rdreq", rdReq, 0);
    chk("midrst_ovf", ovfWarn, 0);
    sb_q.delete();
    fifo_q.delete();
    tick(2);
    clear = 1'b1;
    p0 = rdreq_pulses;
    tick(20);
    chk("post_rst_no_req", rdreq_pulses - p0, 0);
    chk("post_rst_txd", txd, 1);

    // Random words with random enable gaps.
    for (int i = 0; i < 40; i++) begin
      en = 1'b1;
      push(8'($urandom));
      if ($urandom_range(0, 3) == 0) begin
        en = 1'b0;
        tick($urandom_range(1, 60));
        en = 1'b1;
      end
      tick($urandom_range(0, 30));
    end
    en = 1'b1;
    wait_idle("random");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
